imm_instr_encoder: RTL and testbench
====================================

// Module: imm_instr_encoder
// PURPOSE
//  Inverse of the immediate generator: packs opcode, register fields and a 32-bit immediate into one RV32I instruction word.
//  Covers I/I-load/JALR, S, B, U (LUI/AUIPC), J and R formats, and range-checks the immediate against each format.
//  Encoded words go through a small output FIFO with valid/ready on both sides.
//  Used by the boot/self-test program generator and by the testbench stimulus path.
// PARAMETERS
//  DEPTH    2   output FIFO entries (power of two, >=2)
//  CNT_W    8   width of saturating error counter
//  Type_U 7'b011_0111, Type_AUIPC 7'b001_0111, Type_J 7'b110_1111, Type_B 7'b110_0011,
//  Type_Ijalr 7'b110_0111, Type_I_l 7'b000_0011, Type_S 7'b010_0011, Type_I 7'b001_0011, Type_R 7'b011_0011
// PORTS
//  i_clk       in   1      clock, rising edge
//  i_rst_n     in   1      asynchronous active-low reset
//  i_Valid     in   1      input fields valid
//  o_Ready     out  1      encoder can accept (FIFO not full)
//  iv_Opcode   in   7      opcode
//  iv_Rd       in   5      rd
//  iv_Rs1      in   5      rs1
//  iv_Rs2      in   5      rs2
//  iv_Funct3   in   3      funct3
//  iv_Funct7   in   7      funct7 (R only)
//  iv_Imm      in   32     immediate as a full two's-complement value (U: final value, low 12 bits 0)
//  o_Valid     out  1      FIFO head valid
//  i_Ready     in   1      consumer accepts head
//  ov_Data     out  32     encoded instruction
//  o_Err       out  1      head word flagged illegal (ov_Data = 0)
//  ov_ErrCnt   out  CNT_W  saturating count of accepted words flagged illegal
// BEHAVIOUR
//  Reset: FIFO empty, o_Valid=0, ov_Data=0, o_Err=0, ov_ErrCnt=0, o_Ready=1. Reset during a transfer drops all entries.
//  Push when i_Valid&&o_Ready; pop when o_Valid&&i_Ready. o_Ready = !full, from registered count only.
//  Latency: word pushed at edge N appears at head, o_Valid=1, after edge N if FIFO was empty. Otherwise FIFO order.
//  Simultaneous push+pop: count unchanged, order kept. Full: o_Ready=0, even if pop happens in the same cycle.
//  Empty: o_Valid=0. ov_Data/o_Err hold the last value.
//  Encoding, from imm=iv_Imm:
//   I/I_l/Ijalr: {imm[11:0],rs1,f3,rd,op}   legal if imm in [-2048,2047]
//   S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}    legal if imm in [-2048,2047]
//   B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}  legal if in [-4096,4094], imm[0]=0
//   U/AUIPC: {imm[31:12],rd,op}              legal if imm[11:0]=0
//   J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}  legal if in [-2^20,2^20-2], imm[0]=0
//   R: {f7,rs2,rs1,f3,rd,op}                 always legal; imm ignored
//   Any other opcode, or a range/alignment failure: store word 0 with err=1.
//  Range check: imm[31:k-1] all equal (sign-extension test), where k = field width.
//  ov_ErrCnt increments on each push of an err=1 word and saturates at all-ones.
//  FIFO pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
// TESTING
//  addi x1,x0,-1 (op 0010011, rd1, imm FFFFFFFF) -> ov_Data 0xFFF00093, o_Err 0, valid one cycle after push
//  sw x2,4(x1) -> 0x0020A223; beq x0,x0,+8 -> 0x00000463; lui x5 imm 0x12345000 -> 0x123452B7
//  jal x1,-4 -> 0xFFDFF0EF; addi imm 2048 -> data 0, o_Err 1, ErrCnt 1; beq imm 7 -> o_Err 1; opcode 1111111 -> o_Err 1
//  i_Ready=0, 3 back-to-back pushes (DEPTH=2) -> o_Ready=0 after 2nd, 3rd held; i_Ready=1 -> words drain in order
//  Full FIFO, push+pop in the same cycle -> push refused, count becomes 1; count>0 and <DEPTH, push+pop -> count unchanged
//  Reset asserted mid-stream with 2 entries -> o_Valid 0, ErrCnt 0 immediately; 300 illegal pushes -> ErrCnt 255

Source files
------------

// File: rtl/imm_instr_encoder.sv
// RV32I instruction encoder: packs opcode, register fields and an immediate into one
// instruction word, range-checks the immediate, and queues results in a small output FIFO.
module imm_instr_encoder #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [6:0]       iv_Opcode,
    input  logic [4:0]       iv_Rd,
    input  logic [4:0]       iv_Rs1,
    input  logic [4:0]       iv_Rs2,
    input  logic [2:0]       iv_Funct3,
    input  logic [6:0]       iv_Funct7,
    input  logic [31:0]      iv_Imm,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [31:0]      ov_Data,
    output logic             o_Err,
    output logic [CNT_W-1:0] ov_ErrCnt
);

    localparam logic [6:0] Type_U     = 7'b011_0111;
    localparam logic [6:0] Type_AUIPC = 7'b001_0111;
    localparam logic [6:0] Type_J     = 7'b110_1111;
    localparam logic [6:0] Type_B     = 7'b110_0011;
    localparam logic [6:0] Type_Ijalr = 7'b110_0111;
    localparam logic [6:0] Type_I_l   = 7'b000_0011;
    localparam logic [6:0] Type_S     = 7'b010_0011;
    localparam logic [6:0] Type_I     = 7'b001_0011;
    localparam logic [6:0] Type_R     = 7'b011_0011;

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    logic        imm_ok12, imm_ok13, imm_ok21;
    logic        enc_err;
    logic [31:0] enc_data;

    // Sign-extension test: every bit above the field's sign bit must equal it.
    assign imm_ok12 = (&iv_Imm[31:11]) | ~(|iv_Imm[31:11]);
    assign imm_ok13 = (&iv_Imm[31:12]) | ~(|iv_Imm[31:12]);
    assign imm_ok21 = (&iv_Imm[31:20]) | ~(|iv_Imm[31:20]);

    always_comb begin
        enc_data = '0;
        enc_err  = 1'b0;
        case (iv_Opcode)
            Type_I, Type_I_l, Type_Ijalr: begin
                enc_err  = !imm_ok12;
                enc_data = {iv_Imm[11:0], iv_Rs1, iv_Funct3, iv_Rd, iv_Opcode};
            end
            Type_S: begin
                enc_err  = !imm_ok12;
                enc_data = {iv_Imm[11:5], iv_Rs2, iv_Rs1, iv_Funct3, iv_Imm[4:0], iv_Opcode};
            end
            Type_B: begin
                enc_err  = !imm_ok13 || iv_Imm[0];
                enc_data = {iv_Imm[12], iv_Imm[10:5], iv_Rs2, iv_Rs1, iv_Funct3,
                            iv_Imm[4:1], iv_Imm[11], iv_Opcode};
            end
            Type_U, Type_AUIPC: begin
                enc_err  = |iv_Imm[11:0];
                enc_data = {iv_Imm[31:12], iv_Rd, iv_Opcode};
            end
            Type_J: begin
                enc_err  = !imm_ok21 || iv_Imm[0];
                enc_data = {iv_Imm[20], iv_Imm[10:1], iv_Imm[11], iv_Imm[19:12], iv_Rd, iv_Opcode};
            end
            Type_R: begin
                enc_data = {iv_Funct7, iv_Rs2, iv_Rs1, iv_Funct3, iv_Rd, iv_Opcode};
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) enc_data = '0;
    end

    logic [32:0]       mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0] count_q;
    logic [32:0]       hold_q;
    logic [32:0]       head;
    logic [CNT_W-1:0]  err_cnt_q;
    logic              push, pop;

    assign o_Ready   = (count_q != CountW'(DEPTH));
    assign o_Valid   = (count_q != '0);
    assign push      = i_Valid && o_Ready;
    assign pop       = o_Valid && i_Ready;
    assign head      = mem_q[rd_ptr_q];
    // When empty, the last shown head word stays on the outputs.
    assign {o_Err, ov_Data} = o_Valid ? head : hold_q;
    assign ov_ErrCnt = err_cnt_q;

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= {enc_err, enc_data};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            hold_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CountW'(1);
                2'b01:   count_q <= count_q - CountW'(1);
                default: count_q <= count_q;
            endcase
            if (o_Valid) hold_q <= head;
            if (push && enc_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Self-checking bench for imm_instr_encoder: reference encoder model plus a FIFO scoreboard.
module tb_imm_instr_encoder;

    localparam int DEPTH = 2;

    logic        clk, rst_n;
    logic        valid_in, ready_out, valid_out, ready_in;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm, data;
    logic        err;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];
    logic [32:0] last_word = '0;
    int mdl_err = 0;

    imm_instr_encoder #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_Valid(valid_in), .o_Ready(ready_out),
        .iv_Opcode(opcode), .iv_Rd(rd), .iv_Rs1(rs1), .iv_Rs2(rs2), .iv_Funct3(funct3),
        .iv_Funct7(funct7), .iv_Imm(imm), .o_Valid(valid_out), .i_Ready(ready_in),
        .ov_Data(data), .o_Err(err), .ov_ErrCnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder using signed range comparisons.
    function automatic logic [32:0] model_enc(logic [6:0] op, logic [4:0] d, logic [4:0] s1,
                                              logic [4:0] s2, logic [2:0] f3, logic [6:0] f7,
                                              logic [31:0] im);
        int s;
        s = int'(signed'(im));
        case (op)
            7'h13, 7'h03, 7'h67:
                if (s >= -2048 && s <= 2047) return {1'b0, im[11:0], s1, f3, d, op};
            7'h23:
                if (s >= -2048 && s <= 2047) return {1'b0, im[11:5], s2, s1, f3, im[4:0], op};
            7'h63:
                if (s >= -4096 && s <= 4094 && (s % 2) == 0)
                    return {1'b0, im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
            7'h37, 7'h17:
                if ((s & 32'hFFF) == 0) return {1'b0, im[31:12], d, op};
            7'h6F:
                if (s >= -(1 << 20) && s <= (1 << 20) - 2 && (s % 2) == 0)
                    return {1'b0, im[20], im[10:1], im[11], im[19:12], d, op};
            7'h33: return {1'b0, f7, s2, s1, f3, d, op};
            default: ;
        endcase
        return {1'b1, 32'h0};
    endfunction

    task automatic set_fields(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
        opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = 7'h20; imm = im;
    endtask

    // One clock of stimulus; keeps the scoreboard queue and error-count model in step.
    task automatic step(input bit v, input bit r);
        bit acc, pp;
        logic [32:0] e;
        valid_in = v;
        ready_in = r;
        acc = v && (exp_q.size() < DEPTH);
        pp  = r && (exp_q.size() > 0);
        e   = model_enc(opcode, rd, rs1, rs2, funct3, funct7, imm);
        @(posedge clk);
        if (pp) last_word = exp_q.pop_front();
        if (acc) begin
            exp_q.push_back(e);
            if (e[32] && mdl_err < 255) mdl_err++;
        end
        #1;
        valid_in = 1'b0;
        ready_in = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid_out); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_valid2: got %b want 0", valid_out); end
        n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", ready_out); end
        n_cmp++; if (data !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", data); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_errcnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_vectors;
        logic [6:0]  v_op  [8] = '{7'h13, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h13, 7'h63, 7'h7F};
        logic [4:0]  v_rd  [8] = '{5'd1, 5'd0, 5'd0, 5'd5, 5'd1, 5'd1, 5'd0, 5'd1};
        logic [4:0]  v_rs1 [8] = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [4:0]  v_rs2 [8] = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [2:0]  v_f3  [8] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        logic [31:0] v_imm [8] = '{32'hFFFFFFFF, 32'd4, 32'd8, 32'h12345000, 32'hFFFFFFFC,
                                   32'd2048, 32'd7, 32'd0};
        logic [31:0] v_dat [8] = '{32'hFFF00093, 32'h0020A223, 32'h00000463, 32'h123452B7,
                                   32'hFFDFF0EF, 32'h0, 32'h0, 32'h0};
        logic        v_err [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0]  v_cnt [8] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
        for (int i = 0; i < 8; i++) begin
            set_fields(v_op[i], v_rd[i], v_rs1[i], v_rs2[i], v_f3[i], v_imm[i]);
            step(1'b1, 1'b0);
            n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL vec_valid[%0d]: got %b want 1", i, valid_out); end
            n_cmp++; if (data !== v_dat[i]) begin n_bad++; $display("FAIL vec_data[%0d]: got %h want %h", i, data, v_dat[i]); end
            n_cmp++; if (err !== v_err[i]) begin n_bad++; $display("FAIL vec_err[%0d]: got %b want %b", i, err, v_err[i]); end
            n_cmp++; if (err_cnt !== v_cnt[i]) begin n_bad++; $display("FAIL vec_errcnt[%0d]: got %0d want %0d", i, err_cnt, v_cnt[i]); end
            step(1'b0, 1'b1);
        end
    endtask

    task automatic test_back_to_back;
        int drained = 0;
        for (int i = 1; i <= 3; i++) begin
            set_fields(7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 32'(i * 100));
            step(1'b1, 1'b0);
            if (i >= 2) begin
                n_cmp++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 0", i, ready_out); end
            end
        end
        for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
            n_cmp++; if ({err, data} !== exp_q[0]) begin n_bad++; $display("FAIL b2b_order[%0d]: got %h want %h", k, {err, data}, exp_q[0]); end
            step(1'b0, 1'b1);
            drained++;
        end
        n_cmp++; if (drained !== 2) begin n_bad++; $display("FAIL b2b_drained: got %0d want 2", drained); end
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b want 0", valid_out); end
        n_cmp++; if (data !== last_word[31:0]) begin n_bad++; $display("FAIL b2b_hold: got %h want %h", data, last_word[31:0]); end
    endtask

    task automatic test_full_pushpop;
        set_fields(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 32'h0);
        step(1'b1, 1'b0);
        set_fields(7'h33, 5'd4, 5'd5, 5'd6, 3'd7, 32'h0);
        step(1'b1, 1'b0);
        set_fields(7'h33, 5'd7, 5'd8, 5'd9, 3'd1, 32'h0);
        step(1'b1, 1'b1);
        n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL full_pp_ready: got %b want 1", ready_out); end
        n_cmp++; if ({err, data} !== exp_q[0]) begin n_bad++; $display("FAIL full_pp_head: got %h want %h", {err, data}, exp_q[0]); end
        set_fields(7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 32'hABCDE000);
        step(1'b1, 1'b1);
        n_cmp++; if (valid_out !== 1'b1 || ready_out !== 1'b1) begin n_bad++; $display("FAIL mid_pp_count: got v%b r%b want v1 r1", valid_out, ready_out); end
        n_cmp++; if ({err, data} !== exp_q[0]) begin n_bad++; $display("FAIL mid_pp_head: got %h want %h", {err, data}, exp_q[0]); end
        step(1'b0, 1'b1);
    endtask

    task automatic test_random;
        logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
        logic [31:0] im;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: im = 32'(int'($urandom_range(0, 10000)) - 5000);
                1: im = $urandom();
                2: im = $urandom() & 32'hFFFFF000;
                default: im = 32'(int'($urandom_range(0, 4194304)) - 2097152);
            endcase
            set_fields(ops[$urandom_range(0, 9)], 5'($urandom()), 5'($urandom()),
                       5'($urandom()), 3'($urandom()), im);
            funct7 = 7'($urandom());
            n_cmp++; if (valid_out !== (exp_q.size() > 0)) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, valid_out, exp_q.size() > 0); end
            n_cmp++; if (ready_out !== (exp_q.size() < DEPTH)) begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, ready_out, exp_q.size() < DEPTH); end
            n_cmp++; if (err_cnt !== 8'(mdl_err)) begin n_bad++; $display("FAIL rnd_errcnt[%0d]: got %0d want %0d", i, err_cnt, mdl_err); end
            if (exp_q.size() > 0) begin
                n_cmp++; if ({err, data} !== exp_q[0]) begin n_bad++; $display("FAIL rnd_head[%0d]: got %h want %h", i, {err, data}, exp_q[0]); end
            end
            step(1'($urandom()), ($urandom_range(0, 3) != 0));
        end
    endtask

    task automatic test_reset_mid;
        set_fields(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        mdl_err = 0;
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", valid_out); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL rstmid_errcnt: got %0d want 0", err_cnt); end
        n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", ready_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturate;
        set_fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00010000);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1);
        n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_errcnt: got %0d want 255", err_cnt); end
        n_cmp++; if (err_cnt !== 8'(mdl_err)) begin n_bad++; $display("FAIL sat_model: got %0d want %0d", err_cnt, mdl_err); end
        n_cmp++; if ({err, data} !== 33'h1_0000_0000) begin n_bad++; $display("FAIL sat_head: got %h want 100000000", {err, data}); end
        step(1'b0, 1'b1);
    endtask

    initial begin
        valid_in = 1'b0;
        ready_in = 1'b0;
        set_fields(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
        test_reset();
        test_vectors();
        test_back_to_back();
        test_full_pushpop();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
